// File: rtl/sample_pipe_pkg.sv
// Shared constants and width helpers for the sample pipeline between the
// phase/amplitude generator and the DAC output stage.
package sample_pipe_pkg;

   localparam int DEFAULT_WIDTH = 12;
   localparam int DEFAULT_DEPTH = 4;

   // A one-stage tap would otherwise need a zero-width select.
   function automatic int tap_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sample_pipe_if.sv
// Valid/ready sample bus: upstream (IN_*) and downstream (OUT_*) handshakes.
interface sample_pipe_if
   import sample_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] IN_DATA;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] OUT_DATA;

   // master: the environment feeding and draining the pipe
   modport master (
      output IN_VALID, IN_DATA, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA
   );

   // slave: the pipe itself
   modport slave (
      input  IN_VALID, IN_DATA, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA
   );
endinterface

// File: rtl/sample_pipe_stage.sv
// One pipeline slot: WIDTH-bit data register plus its valid bit.
module pipe_stage #(
   parameter int               WIDTH     = 12,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             LOAD,
   input  logic             D_VALID,
   input  logic [WIDTH-1:0] D,
   output logic             Q_VALID,
   output logic [WIDTH-1:0] Q
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Data only moves with a real sample, and flush leaves data untouched.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid <= 1'b0;
         r_data  <= RESET_VAL;
      end else begin
         if (FLUSH)     r_valid <= 1'b0;
         else if (LOAD) r_valid <= D_VALID;
         if (LOAD && D_VALID && !FLUSH) r_data <= D;
      end
   end

   assign Q_VALID = r_valid;
   assign Q       = r_data;

endmodule

// File: rtl/sample_pipe.sv
// Stallable, bubble-collapsing sample pipeline with flush, debug tap and
// occupancy count.
module sample_pipe
   import sample_pipe_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter int               DEPTH     = DEFAULT_DEPTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      FLUSH,
   input  logic [tap_w(DEPTH)-1:0]   TAP_SEL,
   output logic [WIDTH-1:0]          TAP_DATA,
   output logic                      TAP_VALID,
   output logic [occ_w(DEPTH)-1:0]   OCCUPANCY,
   sample_pipe_if.slave              bus
);

   localparam int OW = occ_w(DEPTH);

   logic [DEPTH-1:0]            w_adv;
   logic [DEPTH-1:0]            w_valid;
   logic [DEPTH-1:0][WIDTH-1:0] w_q;
   logic                        w_in_ready;
   logic                        w_accept;
   logic                        w_consume;
   logic [OW-1:0]               r_occ;

   // Ready chain from the output backwards: an empty slot frees everything
   // behind it, which is what collapses bubbles under a stalled output.
   always_comb begin
      logic v_run;
      v_run = !w_valid[DEPTH-1] || bus.OUT_READY;
      w_adv = '0;
      w_adv[DEPTH-1] = v_run;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         v_run    = !w_valid[i] || v_run;
         w_adv[i] = v_run;
      end
   end

   assign w_in_ready = w_adv[0] && !FLUSH && !RST;
   assign w_accept   = bus.IN_VALID && w_in_ready;
   assign w_consume  = w_valid[DEPTH-1] && bus.OUT_READY;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_d_valid;
      logic [WIDTH-1:0] w_d;
      if (i == 0) begin : g_head
         assign w_d_valid = w_accept;
         assign w_d       = bus.IN_DATA;
      end else begin : g_body
         assign w_d_valid = w_valid[i-1];
         assign w_d       = w_q[i-1];
      end
      pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .CLK     (CLK),
         .RST     (RST),
         .FLUSH   (FLUSH),
         .LOAD    (w_adv[i]),
         .D_VALID (w_d_valid),
         .D       (w_d),
         .Q_VALID (w_valid[i]),
         .Q       (w_q[i])
      );
   end

   // Tracks popcount(valid) without an adder tree over the valid bits.
   always_ff @(posedge CLK) begin
      if (RST || FLUSH)               r_occ <= '0;
      else if (w_accept && !w_consume) r_occ <= r_occ + OW'(1);
      else if (!w_accept && w_consume) r_occ <= r_occ - OW'(1);
   end

   // Out-of-range selects only exist for non-power-of-two depths.
   always_comb begin
      TAP_DATA  = RESET_VAL;
      TAP_VALID = 1'b0;
      if (int'(TAP_SEL) < DEPTH) begin
         TAP_DATA  = w_q[TAP_SEL];
         TAP_VALID = w_valid[TAP_SEL];
      end
   end

   assign bus.IN_READY  = w_in_ready;
   assign bus.OUT_VALID = w_valid[DEPTH-1];
   assign bus.OUT_DATA  = w_q[DEPTH-1];
   assign OCCUPANCY     = r_occ;

endmodule

// File: tb/tb_sample_pipe.sv
// Directed bench for sample_pipe at WIDTH=12, DEPTH=4.
module tb_sample_pipe;

   localparam int WIDTH = 12;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [1:0]       tap_sel;
   logic [WIDTH-1:0] tap_data;
   logic             tap_valid;
   logic [2:0]       occ;

   int checks = 0;
   int errors = 0;

   sample_pipe_if #(.WIDTH(WIDTH)) bus ();

   sample_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(12'h000)) dut (
      .CLK       (clk),
      .RST       (rst),
      .FLUSH     (flush),
      .TAP_SEL   (tap_sel),
      .TAP_DATA  (tap_data),
      .TAP_VALID (tap_valid),
      .OCCUPANCY (occ),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; tap_sel = 2'd0;
      bus.IN_VALID = 1'b0; bus.IN_DATA = '0; bus.OUT_READY = 1'b0;
      tick(); tick();
      checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.OUT_VALID); end
      checks++; if (bus.OUT_DATA !== 12'h000) begin errors++; $display("FAIL rst_out_data got %h exp 000", bus.OUT_DATA); end
      checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occ); end
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready_hi got %b exp 0", bus.IN_READY); end
      rst = 1'b0;
      #1;
      checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after got %b exp 1", bus.IN_READY); end
   endtask

   task automatic test_stream();
      int peak = 0;
      bus.OUT_READY = 1'b1;
      for (int c = 0; c < 13; c++) begin
         bus.IN_VALID = (c < 8);
         bus.IN_DATA  = 12'(c + 1);
         tick();
         if (int'(occ) > peak) peak = int'(occ);
         checks++;
         if (bus.OUT_VALID !== ((c >= 3) && (c <= 10))) begin
            errors++; $display("FAIL stream_valid edge %0d got %b", c, bus.OUT_VALID);
         end
         if (c >= 3 && c <= 10) begin
            checks++;
            if (bus.OUT_DATA !== 12'(c - 2)) begin
               errors++; $display("FAIL stream_data edge %0d got %h exp %h", c, bus.OUT_DATA, 12'(c - 2));
            end
         end
      end
      checks++; if (peak != 4) begin errors++; $display("FAIL stream_occ_peak got %0d exp 4", peak); end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int n   = 0;
      logic [WIDTH-1:0] got [8];
      logic acc;
      bus.OUT_READY = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus.IN_VALID = (idx < 6);
         bus.IN_DATA  = 12'h010 + 12'(idx);
         #1;
         acc = bus.IN_VALID && bus.IN_READY;
         tick();
         if (acc) idx++;
         if (c >= 3) begin
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 12'h010) begin
               errors++; $display("FAIL bp_hold edge %0d got v=%b d=%h exp v=1 d=010", c, bus.OUT_VALID, bus.OUT_DATA);
            end
         end
      end
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 12'h010 + 12'(idx);
      #1;
      checks++; if (idx != 4) begin errors++; $display("FAIL bp_accepts got %0d exp 4", idx); end
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.IN_READY); end
      checks++; if (occ !== 3'd4) begin errors++; $display("FAIL bp_occ got %0d exp 4", occ); end
      bus.OUT_READY = 1'b1;
      #1;
      checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL bp_full_stream_ready got %b exp 1", bus.IN_READY); end
      for (int c = 0; c < 20; c++) begin
         bus.IN_VALID = (idx < 6);
         bus.IN_DATA  = 12'h010 + 12'(idx);
         #1;
         acc = bus.IN_VALID && bus.IN_READY;
         if (bus.OUT_VALID && bus.OUT_READY) begin
            if (n < 8) got[n] = bus.OUT_DATA;
            n++;
         end
         tick();
         if (acc) idx++;
      end
      bus.IN_VALID = 1'b0;
      checks++; if (n != 6) begin errors++; $display("FAIL bp_drain_count got %0d exp 6", n); end
      for (int k = 0; k < 6 && k < n; k++) begin
         checks++;
         if (got[k] !== 12'h010 + 12'(k)) begin
            errors++; $display("FAIL bp_drain_order idx %0d got %h exp %h", k, got[k], 12'h010 + 12'(k));
         end
      end
      checks++; if (occ !== 3'd0) begin errors++; $display("FAIL bp_occ_empty got %0d exp 0", occ); end
   endtask

   task automatic test_bubble();
      bus.OUT_READY = 1'b0;
      bus.IN_VALID = 1'b1; bus.IN_DATA = 12'h00A; tick();
      bus.IN_VALID = 1'b0; tick();
      bus.IN_VALID = 1'b1; bus.IN_DATA = 12'h00B; tick();
      bus.IN_VALID = 1'b0;
      tick(); tick(); tick();
      checks++; if (occ !== 3'd2) begin errors++; $display("FAIL bub_occ got %0d exp 2", occ); end
      checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL bub_in_ready got %b exp 1", bus.IN_READY); end
      tap_sel = 2'd3; #1;
      checks++; if (tap_valid !== 1'b1 || tap_data !== 12'h00A) begin errors++; $display("FAIL bub_stage3 got v=%b d=%h exp v=1 d=00a", tap_valid, tap_data); end
      tap_sel = 2'd2; #1;
      checks++; if (tap_valid !== 1'b1 || tap_data !== 12'h00B) begin errors++; $display("FAIL bub_stage2 got v=%b d=%h exp v=1 d=00b", tap_valid, tap_data); end
      tap_sel = 2'd1; #1;
      checks++; if (tap_valid !== 1'b0) begin errors++; $display("FAIL bub_stage1 got v=%b exp 0", tap_valid); end
      bus.OUT_READY = 1'b1;
      tick();
      checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 12'h00B) begin errors++; $display("FAIL bub_second got v=%b d=%h exp v=1 d=00b", bus.OUT_VALID, bus.OUT_DATA); end
      tick();
      checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL bub_empty got %b exp 0", bus.OUT_VALID); end
   endtask

   task automatic test_flush();
      int seen = 0;
      bus.OUT_READY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.IN_VALID = 1'b1; bus.IN_DATA = 12'h021 + 12'(k); tick();
      end
      bus.IN_VALID = 1'b0; tick();
      checks++; if (occ !== 3'd3) begin errors++; $display("FAIL fl_pre_occ got %0d exp 3", occ); end
      checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_DATA !== 12'h021) begin errors++; $display("FAIL fl_pre_out got v=%b d=%h exp v=1 d=021", bus.OUT_VALID, bus.OUT_DATA); end
      flush = 1'b1; bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1; bus.IN_DATA = 12'h02F;
      #1;
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %b exp 0", bus.IN_READY); end
      tick();
      flush = 1'b0; bus.IN_VALID = 1'b0;
      checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL fl_out_valid got %b exp 0", bus.OUT_VALID); end
      checks++; if (occ !== 3'd0) begin errors++; $display("FAIL fl_occ got %0d exp 0", occ); end
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.OUT_VALID) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL fl_leak got %0d outputs exp 0", seen); end
   endtask

   task automatic test_rst_mid();
      int seen = 0;
      bus.OUT_READY = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.IN_VALID = 1'b1; bus.IN_DATA = 12'h031 + 12'(k); tick();
      end
      checks++; if (occ !== 3'd4) begin errors++; $display("FAIL rm_full got %0d exp 4", occ); end
      rst = 1'b1; tick();
      checks++; if (bus.OUT_VALID !== 1'b0 || bus.OUT_DATA !== 12'h000) begin errors++; $display("FAIL rm_out got v=%b d=%h exp v=0 d=000", bus.OUT_VALID, bus.OUT_DATA); end
      checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rm_occ got %0d exp 0", occ); end
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL rm_in_ready got %b exp 0", bus.IN_READY); end
      rst = 1'b0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (bus.OUT_VALID) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rm_leak got %0d outputs exp 0", seen); end
   endtask

   task automatic test_tap();
      bus.OUT_READY = 1'b0;
      bus.IN_VALID = 1'b1; bus.IN_DATA = 12'h0AA; tick();
      bus.IN_DATA = 12'h123; tick();
      bus.IN_VALID = 1'b0;
      tick(); tick(); tick();
      tap_sel = 2'd2; #1;
      checks++; if (tap_data !== 12'h123 || tap_valid !== 1'b1) begin errors++; $display("FAIL tap2 got v=%b d=%h exp v=1 d=123", tap_valid, tap_data); end
      tap_sel = 2'd3; #1;
      checks++; if (tap_data !== 12'h0AA || tap_valid !== 1'b1) begin errors++; $display("FAIL tap3 got v=%b d=%h exp v=1 d=0aa", tap_valid, tap_data); end
      tap_sel = 2'd0; #1;
      checks++; if (tap_valid !== 1'b0) begin errors++; $display("FAIL tap0 got v=%b exp 0", tap_valid); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_rst_mid();
      test_tap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
